seg_scan_ctrl: RTL

//  Time-multiplexes one shared sevenseg decoder across NUM_DIGITS common-anode digits to show the snake score.

---
 rtl/seg_scan_ctrl_pkg.sv | 20 ++
 rtl/bin2bcd_seq.sv | 95 +++++++++
 rtl/sevenseg.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 87 ++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed seven-segment score display.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_OFF   = 7'b111_1111;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with saturation and a one-deep pending request slot.
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    bcd_valid,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

  conv_state_t        state, state_n;
  logic [VALUE_W-1:0] sh, cap, pend_val, ld_val;
  logic [BCD_W-1:0]   acc, acc_adj, acc_shift;
  logic [CNT_W-1:0]   cnt;
  logic               pending, ld;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state: a load arriving during COMMIT, or one already pending, chains straight into SHIFT.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (start) state_n = ST_SHIFT;
      ST_SHIFT:  if (cnt == CNT_W'(VALUE_W - 1)) state_n = ST_COMMIT;
      ST_COMMIT: state_n = (start || pending) ? ST_SHIFT : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Add-3 adjust on each nibble, then shift in the next binary bit.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[BCD_W-2:0], sh[VALUE_W-1]};
  end

  // Start selection: a fresh load in COMMIT supersedes the pending value (newest wins).
  always_comb begin
    ld     = ((state == ST_IDLE) && start) || ((state == ST_COMMIT) && (start || pending));
    ld_val = ((state == ST_COMMIT) && !start) ? pend_val : bin;
  end

  // Conversion datapath and pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh       <= '0;
      cap      <= '0;
      acc      <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
    end else begin
      if (ld) begin
        sh  <= ld_val;
        cap <= ld_val;
        acc <= '0;
        cnt <= '0;
      end else if (state == ST_SHIFT) begin
        sh  <= sh << 1;
        acc <= acc_shift;
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == ST_SHIFT) && start) begin
        pending  <= 1'b1;
        pend_val <= bin;
      end else if (state == ST_COMMIT) begin
        pending <= 1'b0;
      end
    end
  end

  // A superseded result is dropped so the display never shows it.
  always_comb begin
    busy      = (state != ST_IDLE);
    bcd_valid = (state == ST_COMMIT) && !start && !pending;
    bcd       = (32'(cap) > MAX_VAL) ? {NUM_DIGITS{4'h9}} : acc;
  end

endmodule

// File: rtl/sevenseg.sv
// Active-low {g..a} decoder for decimal digits; any other code drives all segments off.
module sevenseg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [31:0] value,
  output logic [6:0]  seg
);

  // Decode one decimal digit; upper bits set or codes above 9 blank the digit.
  always_comb begin
    seg = SEG_OFF;
    if (value[31:4] == '0) begin
      case (value[3:0])
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_OFF;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Score display: BCD conversion, digit scanning, leading-zero blanking and registered pin drive.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp, bcd;
  logic                    bcd_valid, upper_zero;
  logic [3:0]              code;
  logic [6:0]              seg_dec;

  bin2bcd_seq #(
    .NUM_DIGITS(NUM_DIGITS),
    .VALUE_W   (VALUE_W)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .start    (load),
    .bin      (value),
    .busy     (busy),
    .bcd_valid(bcd_valid),
    .bcd      (bcd)
  );

  // Display register only takes complete conversions.
  always_ff @(posedge clk) begin
    if (rst)            disp <= '0;
    else if (bcd_valid) disp <= bcd;
  end

  // Free-running scan divider and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Blank the current digit when it and every more-significant digit is zero (digit 0 always shown).
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= 32'(idx)) && (disp[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    code = disp[{idx, 2'b00} +: 4];
    if (blank_lz && (idx != '0) && upper_zero) code = BCD_BLANK;
  end

  sevenseg u_seg (
    .value({28'b0, code}),
    .seg  (seg_dec)
  );

  // Segments and anodes registered together so they always refer to the same digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= '1;
    end else begin
      seg <= seg_dec;
      an  <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule
